// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default vector layout.
package int_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam logic [15:0] VEC_BASE_DEF   = 16'h0010;
  localparam int          VEC_STRIDE_DEF = 4;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index priority encoder: idx_o is the lowest set bit of req_i, valid_o when any bit is set.
module prio_enc #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  // Scan downwards so the last hit, the lowest index, wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Nesting interrupt controller: edge-latched requests, mask, strict-priority preemption
// against the in-service set, and a registered irq/vector pair for the control unit.
module int_ctrl
  import int_pkg::*;
#(
  parameter int               N_INT      = 8,
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(VEC_BASE_DEF),
  parameter int               VEC_STRIDE = VEC_STRIDE_DEF,
  parameter logic [N_INT-1:0] MASK_RST   = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_INT-1:0] int_e,
  input  logic             mask_we,
  input  logic [N_INT-1:0] mask_in,
  input  logic             ack,
  input  logic             reti,
  output logic             irq,
  output logic [VEC_W-1:0] vector,
  output logic [N_INT-1:0] mask_out,
  output logic [N_INT-1:0] in_service,
  output logic             reti_err,
  output state_e           state_dbg
);

  localparam int IDX_W = (N_INT > 1) ? $clog2(N_INT) : 1;

  // Handshake: irq/vector act as valid/data; ack is accepted only while irq is high
  // (REQ) and transfers the presented sel into service. reti is unconditional.
  state_e           state_q;
  logic [N_INT-1:0] int_q, pending_q, pending_d, mask_q, in_service_q, in_service_d;
  logic [IDX_W-1:0] sel_q;
  logic             irq_q, reti_err_q;
  logic [VEC_W-1:0] vector_q;

  logic [N_INT-1:0] rise, cand_req, is_clr, sel_oh;
  logic [IDX_W-1:0] cand_idx, is_idx;
  logic             cand_valid, is_valid, eligible, take;
  logic [VEC_W-1:0] vec_c;

  prio_enc #(.N(N_INT), .W(IDX_W)) u_cand_enc (
    .req_i  (cand_req),
    .idx_o  (cand_idx),
    .valid_o(cand_valid)
  );

  prio_enc #(.N(N_INT), .W(IDX_W)) u_isv_enc (
    .req_i  (in_service_q),
    .idx_o  (is_idx),
    .valid_o(is_valid)
  );

  assign rise     = int_e & ~int_q;
  assign cand_req = pending_q & mask_q;
  assign eligible = cand_valid && (!is_valid || (cand_idx < is_idx));
  assign take     = (state_q == ST_REQ) && ack;
  assign vec_c    = VEC_BASE + VEC_W'(cand_idx) * VEC_W'(VEC_STRIDE);
  assign is_clr   = is_valid ? (N_INT'(1) << is_idx) : '0;
  assign sel_oh   = N_INT'(1) << sel_q;

  // reti retires the innermost level before ack adds the new one; a fresh rise beats the ack clear.
  always_comb begin
    in_service_d = in_service_q;
    if (reti) in_service_d = in_service_d & ~is_clr;
    if (take) in_service_d = in_service_d | sel_oh;
    pending_d = pending_q;
    if (take) pending_d = pending_d & ~sel_oh;
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      int_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      mask_q       <= MASK_RST;
      irq_q        <= 1'b0;
      vector_q     <= VEC_BASE;
      sel_q        <= '0;
      reti_err_q   <= 1'b0;
    end else begin
      int_q        <= int_e;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      reti_err_q   <= reti && !is_valid;
      if (mask_we) mask_q <= mask_in;
      case (state_q)
        ST_IDLE: begin
          if (eligible) begin
            state_q  <= ST_REQ;
            irq_q    <= 1'b1;
            vector_q <= vec_c;
            sel_q    <= cand_idx;
          end
        end
        ST_REQ: begin
          if (ack) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end else if (eligible) begin
            irq_q    <= 1'b1;
            vector_q <= vec_c;
            sel_q    <= cand_idx;
          end else begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq        = irq_q;
  assign vector     = vector_q;
  assign mask_out   = mask_q;
  assign in_service = in_service_q;
  assign reti_err   = reti_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_int_ctrl;
  import int_pkg::*;

  localparam int          N      = 8;
  localparam int          VW     = 16;
  localparam logic [15:0] BASE   = 16'h0010;
  localparam int          STRIDE = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  int_e = '0;
  logic [N-1:0]  mask_in = '0;
  logic          mask_we = 1'b0;
  logic          ack = 1'b0;
  logic          reti = 1'b0;
  logic          irq;
  logic [VW-1:0] vector;
  logic [N-1:0]  mask_out;
  logic [N-1:0]  in_service;
  logic          reti_err;
  state_e        state_dbg;

  int_ctrl #(
    .N_INT(N), .VEC_W(VW), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE), .MASK_RST(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .int_e(int_e), .mask_we(mask_we), .mask_in(mask_in),
    .ack(ack), .reti(reti), .irq(irq), .vector(vector), .mask_out(mask_out),
    .in_service(in_service), .reti_err(reti_err), .state_dbg(state_dbg)
  );

  // scoreboard
  int            n_checks = 0;
  int            n_pass = 0;
  logic [VW-1:0] exp_q[$];

  // reference model: what the controller should be showing after each edge
  logic [N-1:0]  m_prev = '0, m_pend = '0, m_mask = '1, m_isv = '0;
  logic          m_irq = 1'b0, m_err = 1'b0;
  logic [VW-1:0] m_vec = BASE;
  int            m_sel = 0;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return N;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    int c, s;
    logic take;
    logic [N-1:0] nxt_isv;
    if (!reset) begin
      m_prev = '0; m_pend = '0; m_isv = '0; m_mask = '1;
      m_irq = 1'b0; m_vec = BASE; m_err = 1'b0; m_sel = 0;
    end else begin
      c = lowest(m_pend & m_mask);
      s = lowest(m_isv);
      take = m_irq && ack;
      nxt_isv = m_isv;
      m_err = reti && (m_isv == '0);
      if (reti && s < N) nxt_isv[s] = 1'b0;
      if (take) begin
        nxt_isv[m_sel] = 1'b1;
        m_pend[m_sel] = 1'b0;
      end
      m_pend = m_pend | (int_e & ~m_prev);
      if (take) m_irq = 1'b0;
      else if (c < s) begin
        m_irq = 1'b1;
        m_sel = c;
        m_vec = BASE + VW'(c * STRIDE);
      end else m_irq = 1'b0;
      m_isv = nxt_isv;
      if (mask_we) m_mask = mask_in;
      m_prev = int_e;
    end
  endtask

  // driver: one clock with full output comparison
  task automatic cycle();
    if (reset && m_irq && ack) begin
      exp_q.push_back(m_vec);
      check("ack_vector", vector, exp_q.pop_front());
    end
    model_edge();
    @(posedge clk);
    #1;
    check("irq", irq, m_irq);
    check("state", state_dbg == ST_REQ, m_irq);
    if (m_irq) check("vector", vector, m_vec);
    if (!reset) check("rst_vector", vector, BASE);
    check("mask_out", mask_out, m_mask);
    check("in_service", in_service, m_isv);
    check("reti_err", reti_err, m_err);
  endtask

  task automatic do_ack();
    ack = 1'b1; cycle(); ack = 1'b0;
  endtask

  task automatic do_reti();
    reti = 1'b1; cycle(); reti = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; cycle(); reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
    check("rst_mask", mask_out, 8'hFF);
    check("rst_irq", irq, 0);

    // single request, latency and ack
    int_e = 8'h08; cycle();
    check("t1_lat1", irq, 0);
    cycle();
    check("t1_irq", irq, 1);
    check("t1_vec", vector, 16'h001C);
    do_ack();
    check("t1_isv", in_service, 8'h08);
    check("t1_irq_ack", irq, 0);
    int_e = 8'h00; do_reti();
    check("t1_reti", in_service, 0);

    // nesting: lower blocked, higher preempts
    int_e = 8'h20; cycle(); cycle(); do_ack();
    check("t2_isv5", in_service, 8'h20);
    int_e = 8'h60; repeat (3) cycle();
    check("t2_blocked", irq, 0);
    int_e = 8'h64; cycle(); cycle();
    check("t2_irq", irq, 1);
    check("t2_vec", vector, 16'h0018);
    do_ack();
    check("t2_isv", in_service, 8'h24);
    do_reti();
    check("t2_reti", in_service, 8'h20);
    do_reti();
    check("t2_reti2", in_service, 0);
    cycle();
    check("t2_src6", vector, 16'h0028);
    int_e = 8'h00; do_ack(); do_reti();

    // mask retains pending
    mask_we = 1'b1; mask_in = 8'hFB; int_e = 8'h04; cycle(); mask_we = 1'b0;
    cycle(); cycle();
    check("t3_masked", irq, 0);
    mask_we = 1'b1; mask_in = 8'hFF; cycle(); mask_we = 1'b0;
    check("t3_write_edge", irq, 0);
    cycle();
    check("t3_irq", irq, 1);
    check("t3_vec", vector, 16'h0018);
    int_e = 8'h00; do_ack(); do_reti();

    // higher arrival replaces presented source; lower stays pending
    int_e = 8'h10; cycle(); cycle();
    check("t4_vec4", vector, 16'h0020);
    int_e = 8'h12; cycle();
    check("t4_vec4_hold", vector, 16'h0020);
    cycle();
    check("t4_vec1", vector, 16'h0014);
    do_ack();
    check("t4_isv", in_service, 8'h02);
    cycle();
    check("t4_blocked", irq, 0);
    do_reti(); cycle();
    check("t4_pend4", irq, 1);
    check("t4_pend4_vec", vector, 16'h0020);
    int_e = 8'h00; do_ack(); do_reti();

    // rise on the acked source wins over the clear
    int_e = 8'h08; cycle(); cycle();
    int_e = 8'h00; cycle();
    int_e = 8'h08; do_ack();
    check("t7_isv", in_service, 8'h08);
    cycle();
    check("t7_blocked", irq, 0);
    do_reti(); cycle();
    check("t7_again", irq, 1);
    check("t7_again_vec", vector, 16'h001C);
    int_e = 8'h00; do_ack(); do_reti();

    // reti with nothing in service
    do_reti();
    check("t5_err", reti_err, 1);
    check("t5_isv", in_service, 0);
    cycle();
    check("t5_err_gone", reti_err, 0);

    // reset from REQ with a level in service; held line re-fires after reset
    mask_we = 1'b1; mask_in = 8'h7F; cycle(); mask_we = 1'b0;
    int_e = 8'h02; cycle(); cycle(); do_ack();
    int_e = 8'h03; cycle(); cycle();
    check("t6_req", irq, 1);
    check("t6_vec", vector, 16'h0010);
    do_reset();
    check("t6_irq", irq, 0);
    check("t6_isv", in_service, 0);
    check("t6_mask", mask_out, 8'hFF);
    check("t6_vector", vector, 16'h0010);
    cycle(); cycle();
    check("t6_refire", irq, 1);
    int_e = 8'h00; do_reset();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) int_e = int_e ^ (8'(1) << $urandom_range(0, N - 1));
      mask_we = ($urandom_range(0, 19) == 0);
      mask_in = 8'($urandom_range(0, 255)) | 8'($urandom_range(0, 255));
      ack     = m_irq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      reti    = ($urandom_range(0, 9) == 0);
      reset   = ($urandom_range(0, 399) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
